bounding_box_fp16: RTL and testbench

Computes the integer screen-space bounding box of a triangle given as three FP16 (IEEE 754 binary16) vertices, clamped to a 256×256 image. It sits at the front of the rasterizer pipeline. It converts vertex coordinates into the pixel range that the coverage stage iterates over. It is a multi-cycle, single-job unit: it accepts one triangle on an enable pulse and presents a held result flagged by `valid`.

---
 rtl/bounding_box_fp16.sv | 179 +++++++++++++++++
 tb/tb_bounding_box_fp16.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bounding_box_fp16.sv
// bounding_box_fp16
//   Computes the clamped integer screen-space bounding box of a triangle whose
//   three vertices arrive as FP16 (binary16) coordinates. One job at a time:
//   capture -> MINMAX -> CONVERT -> CLAMP -> DONE, fixed 4-cycle latency.
//
// Ports
//   clk             : clock, rising edge
//   rst_n           : asynchronous reset, ACTIVE HIGH despite the name
//   en              : start strobe, accepted in IDLE or DONE
//   triangle[143:0] : {v0.x,v0.y,v0.z,v1.x,v1.y,v1.z,v2.x,v2.y,v2.z}, FP16 each
//   bbox_*_int      : unsigned clamped pixel bounds, held while valid
//   valid           : bbox outputs hold the result of the last captured triangle
module bounding_box_fp16 #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [143:0] triangle,
  output logic [15:0]  bbox_x_min_int,
  output logic [15:0]  bbox_x_max_int,
  output logic [15:0]  bbox_y_min_int,
  output logic [15:0]  bbox_y_max_int,
  output logic         valid
);

  typedef enum logic [2:0] {IDLE, MINMAX, CONVERT, CLAMP, DONE} state_t;

  localparam logic signed [17:0] X_HI = 18'(IMG_W - 1);
  localparam logic signed [17:0] Y_HI = 18'(IMG_H - 1);

  // Sign-magnitude FP16 mapped onto a signed key so that an ordinary signed
  // compare orders the values; -0 and +0 both map to key 0.
  function automatic logic signed [16:0] fp16_key(input logic [15:0] h);
    logic signed [16:0] mag;
    mag = $signed({2'b00, h[14:0]});
    return h[15] ? -mag : mag;
  endfunction

  function automatic logic [15:0] fp16_pick(input logic [15:0] a, input logic [15:0] b,
                                            input logic want_max);
    if (want_max) return (fp16_key(b) > fp16_key(a)) ? b : a;
    else          return (fp16_key(b) < fp16_key(a)) ? b : a;
  endfunction

  // NaN is handled as +0.0 everywhere downstream.
  function automatic logic [15:0] fp16_sanitize(input logic [15:0] h);
    return ((&h[14:10]) && (|h[9:0])) ? 16'h0000 : h;
  endfunction

  // FP16 -> signed integer, floor (round_up=0) or ceil (round_up=1).
  // Largest finite FP16 is 65504, so only Inf reaches the 2^16 saturation.
  function automatic logic signed [17:0] fp16_to_int(input logic [15:0] h,
                                                     input logic round_up);
    logic [4:0]  e;
    logic [10:0] sig;
    logic [16:0] mag;
    logic [17:0] mag_b;
    logic        frac;
    e    = h[14:10];
    sig  = {|e, h[9:0]};
    mag  = '0;
    frac = 1'b0;
    if (e == 5'd31) begin
      mag = 17'h10000;
    end else if (e < 5'd15) begin
      frac = |h[14:0];                       // |v| < 1, including subnormals
    end else if (e >= 5'd25) begin
      mag = 17'(sig) << (e - 5'd25);         // exact integer, no fraction
    end else begin
      mag  = 17'(sig >> (5'd25 - e));
      frac = |(sig & ((11'd1 << (5'd25 - e)) - 11'd1));
    end
    // Floor of a negative or ceil of a positive moves the magnitude up by one.
    mag_b = 18'(mag) + 18'(frac & (h[15] ^ round_up));
    return h[15] ? -$signed(mag_b) : $signed(mag_b);
  endfunction

  function automatic logic [15:0] clamp_px(input logic signed [17:0] v,
                                           input logic signed [17:0] hi);
    if (v < 0)       return 16'd0;
    else if (v > hi) return 16'(hi);
    else             return 16'(v);
  endfunction

  state_t             state_q, state_d;
  logic [15:0]        x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
  logic [15:0]        fx_min_q, fx_max_q, fy_min_q, fy_max_q;
  logic signed [17:0] ix_min_q, ix_max_q, iy_min_q, iy_max_q;
  logic [15:0]        cx_min_q, cx_max_q, cy_min_q, cy_max_q;
  logic [15:0]        bx_min_q, bx_max_q, by_min_q, by_max_q;
  logic               valid_q;
  logic               capture;
  logic               unused_z;

  assign unused_z = ^{triangle[111:96], triangle[63:48], triangle[15:0]};

  assign capture = en && ((state_q == IDLE) || (state_q == DONE));

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = MINMAX;
      MINMAX:  state_d = CONVERT;
      CONVERT: state_d = CLAMP;
      CLAMP:   state_d = DONE;
      DONE:    if (en) state_d = MINMAX;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  // NOTE: the datapath registers are few and all reset, so a reset mid-job
  // leaves no stale operands behind.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= IDLE;
      {x0_q, y0_q, x1_q, y1_q, x2_q, y2_q} <= '0;
      {fx_min_q, fx_max_q, fy_min_q, fy_max_q} <= '0;
      {ix_min_q, ix_max_q, iy_min_q, iy_max_q} <= '0;
      {cx_min_q, cx_max_q, cy_min_q, cy_max_q} <= '0;
      {bx_min_q, bx_max_q, by_min_q, by_max_q} <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        x0_q <= fp16_sanitize(triangle[143:128]);
        y0_q <= fp16_sanitize(triangle[127:112]);
        x1_q <= fp16_sanitize(triangle[95:80]);
        y1_q <= fp16_sanitize(triangle[79:64]);
        x2_q <= fp16_sanitize(triangle[47:32]);
        y2_q <= fp16_sanitize(triangle[31:16]);
      end
      case (state_q)
        MINMAX: begin
          fx_min_q <= fp16_pick(fp16_pick(x0_q, x1_q, 1'b0), x2_q, 1'b0);
          fx_max_q <= fp16_pick(fp16_pick(x0_q, x1_q, 1'b1), x2_q, 1'b1);
          fy_min_q <= fp16_pick(fp16_pick(y0_q, y1_q, 1'b0), y2_q, 1'b0);
          fy_max_q <= fp16_pick(fp16_pick(y0_q, y1_q, 1'b1), y2_q, 1'b1);
        end
        CONVERT: begin
          ix_min_q <= fp16_to_int(fx_min_q, 1'b0);
          ix_max_q <= fp16_to_int(fx_max_q, 1'b1);
          iy_min_q <= fp16_to_int(fy_min_q, 1'b0);
          iy_max_q <= fp16_to_int(fy_max_q, 1'b1);
        end
        CLAMP: begin
          cx_min_q <= clamp_px(ix_min_q, X_HI);
          cx_max_q <= clamp_px(ix_max_q, X_HI);
          cy_min_q <= clamp_px(iy_min_q, Y_HI);
          cy_max_q <= clamp_px(iy_max_q, Y_HI);
        end
        default: ;
      endcase
      // Output register stage: result and valid load together on the first
      // DONE edge; a new capture drops valid but keeps the old bbox visible.
      if (capture) begin
        valid_q <= 1'b0;
      end else if ((state_q == DONE) && !valid_q) begin
        valid_q  <= 1'b1;
        bx_min_q <= cx_min_q;
        bx_max_q <= cx_max_q;
        by_min_q <= cy_min_q;
        by_max_q <= cy_max_q;
      end
    end
  end

  assign bbox_x_min_int = bx_min_q;
  assign bbox_x_max_int = bx_max_q;
  assign bbox_y_min_int = by_min_q;
  assign bbox_y_max_int = by_max_q;
  assign valid          = valid_q;

endmodule

// File: tb/tb_bounding_box_fp16.sv
// tb_bounding_box_fp16
//   Directed spec cases plus randomized triangles against a real-arithmetic
//   reference model (FP16 decoded to real, min/max, $floor/$ceil, clamp).
module tb_bounding_box_fp16;

  localparam int IMG_W = 256;
  localparam int IMG_H = 256;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [143:0] triangle;
  logic [15:0]  bbox_x_min_int, bbox_x_max_int, bbox_y_min_int, bbox_y_max_int;
  logic         valid;

  int checks = 0;
  int errors = 0;
  int prev_x_min, prev_x_max, prev_y_min, prev_y_max;

  bounding_box_fp16 #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .triangle       (triangle),
    .bbox_x_min_int (bbox_x_min_int),
    .bbox_x_max_int (bbox_x_max_int),
    .bbox_y_min_int (bbox_y_min_int),
    .bbox_y_max_int (bbox_y_max_int),
    .valid          (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_box(input string tag, input int xmn, input int xmx,
                         input int ymn, input int ymx);
    chk({tag, ".x_min"}, 32'(bbox_x_min_int), 32'(xmn));
    chk({tag, ".x_max"}, 32'(bbox_x_max_int), 32'(xmx));
    chk({tag, ".y_min"}, 32'(bbox_y_min_int), 32'(ymn));
    chk({tag, ".y_max"}, 32'(bbox_y_max_int), 32'(ymx));
  endtask

  // Reference model: plain real arithmetic from the FP16 definition.
  function automatic real fp16_val(input logic [15:0] h);
    int  e = int'(h[14:10]);
    int  m = int'(h[9:0]);
    real v;
    if (e == 31)     v = (m != 0) ? 0.0 : 1.0e9;   // NaN -> 0, Inf -> huge
    else if (e == 0) v = m / 16777216.0;           // m * 2^-24
    else begin
      v = 1024.0 + m;
      for (int i = e; i < 25; i++) v = v / 2.0;
      for (int i = 25; i < e; i++) v = v * 2.0;
    end
    return h[15] ? -v : v;
  endfunction

  function automatic int clampi(input real r, input int hi);
    if (r < 0.0) return 0;
    if (r > hi)  return hi;
    return int'(r);
  endfunction

  task automatic model(input logic [143:0] t, output int xmn, output int xmx,
                       output int ymn, output int ymx);
    real xs[3];
    real ys[3];
    real lo_x, hi_x, lo_y, hi_y;
    xs[0] = fp16_val(t[143:128]); ys[0] = fp16_val(t[127:112]);
    xs[1] = fp16_val(t[95:80]);   ys[1] = fp16_val(t[79:64]);
    xs[2] = fp16_val(t[47:32]);   ys[2] = fp16_val(t[31:16]);
    lo_x = xs[0]; hi_x = xs[0]; lo_y = ys[0]; hi_y = ys[0];
    for (int i = 1; i < 3; i++) begin
      if (xs[i] < lo_x) lo_x = xs[i];
      if (xs[i] > hi_x) hi_x = xs[i];
      if (ys[i] < lo_y) lo_y = ys[i];
      if (ys[i] > hi_y) hi_y = ys[i];
    end
    xmn = clampi($floor(lo_x), IMG_W - 1);
    xmx = clampi($ceil(hi_x),  IMG_W - 1);
    ymn = clampi($floor(lo_y), IMG_H - 1);
    ymx = clampi($ceil(hi_y),  IMG_H - 1);
  endtask

  function automatic logic [143:0] pack(input logic [15:0] x0, input logic [15:0] y0,
                                        input logic [15:0] x1, input logic [15:0] y1,
                                        input logic [15:0] x2, input logic [15:0] y2);
    return {x0, y0, 16'h4200, x1, y1, 16'h4600, x2, y2, 16'h4880};
  endfunction

  function automatic logic [15:0] rand_fp16();
    logic       s = 1'($urandom);
    int unsigned sel = $urandom_range(0, 19);
    case (sel)
      0:       return {s, 15'h7c00};
      1:       return {s, 5'h1f, 10'($urandom_range(1, 1023))};
      2:       return {s, 15'h0000};
      3:       return {s, 5'h00, 10'($urandom_range(1, 1023))};
      default: return {s, 5'($urandom_range(1, 23)), 10'($urandom)};
    endcase
  endfunction

  // Capture on edge C, optional ignored en pulse at C+1, check valid low
  // through C+3, result at C+4, then optionally held for `hold` more cycles.
  task automatic run_job(input string tag, input logic [143:0] t, input bit glitch,
                         input logic [143:0] g, input int hold,
                         input int xmn, input int xmx, input int ymn, input int ymx);
    @(negedge clk);
    triangle = t;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk({tag, ".valid_after_capture"}, 32'(valid), 32'd0);
    chk_box({tag, ".old_held"}, prev_x_min, prev_x_max, prev_y_min, prev_y_max);
    for (int k = 1; k <= 3; k++) begin
      if (glitch && k == 1) begin
        triangle = g;
        en = 1'b1;
      end
      @(negedge clk);
      en = 1'b0;
    end
    chk({tag, ".valid_c3"}, 32'(valid), 32'd0);
    @(negedge clk);
    chk({tag, ".valid_c4"}, 32'(valid), 32'd1);
    chk_box(tag, xmn, xmx, ymn, ymx);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk({tag, ".valid_hold"}, 32'(valid), 32'd1);
      chk_box({tag, ".hold"}, xmn, xmx, ymn, ymx);
    end
    prev_x_min = xmn; prev_x_max = xmx; prev_y_min = ymn; prev_y_max = ymx;
  endtask

  initial begin
    int xmn, xmx, ymn, ymx;
    logic [143:0] t;

    rst_n = 1'b1;
    en = 1'b0;
    triangle = '0;
    prev_x_min = 0; prev_x_max = 0; prev_y_min = 0; prev_y_max = 0;
    repeat (3) @(negedge clk);
    chk("reset.valid", 32'(valid), 32'd0);
    chk_box("reset", 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle.valid", 32'(valid), 32'd0);

    run_job("basic", {16'h3c00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600,
                      16'h4700, 16'h4800, 16'h4880}, 1'b0, '0, 13, 1, 7, 2, 8);
    run_job("negative", {16'hbc00, 16'hc000, 16'h4200, 16'h0000, 16'h4800, 16'h4600,
                         16'h4600, 16'hbc00, 16'h4880}, 1'b0, '0, 0, 0, 6, 0, 8);
    run_job("overrange", {16'h5c04, 16'h3c00, 16'h4200, 16'h5bf0, 16'h5bf8, 16'h4600,
                          16'h5c04, 16'h5c04, 16'h4880}, 1'b0, '0, 0, 254, 255, 1, 255);
    run_job("fullcover", pack(16'h5c04, 16'hbc00, 16'hbc00, 16'hc000, 16'h5c04, 16'h5c04),
            1'b0, '0, 0, 0, 255, 0, 255);
    run_job("fraction", pack(16'h3e00, 16'h4080, 16'h4380, 16'h3800, 16'h4000, 16'h4000),
            1'b0, '0, 0, 1, 4, 0, 3);
    run_job("inf", pack(16'h7c00, 16'hfc00, 16'h3c00, 16'h4000, 16'h4200, 16'h4400),
            1'b0, '0, 0, 1, 255, 0, 4);
    run_job("glitch", pack(16'h3e00, 16'h4080, 16'h4380, 16'h3800, 16'h4000, 16'h4000),
            1'b1, pack(16'h5c04, 16'hbc00, 16'hbc00, 16'hc000, 16'h5c04, 16'h5c04),
            2, 1, 4, 0, 3);

    // Reset while the job sits in MINMAX: outputs clear asynchronously.
    @(negedge clk);
    triangle = pack(16'h4400, 16'h4400, 16'h4800, 16'h4800, 16'h4a00, 16'h4a00);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("midreset.valid", 32'(valid), 32'd0);
    chk_box("midreset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    prev_x_min = 0; prev_x_max = 0; prev_y_min = 0; prev_y_max = 0;
    repeat (6) @(negedge clk);
    chk("midreset.aborted", 32'(valid), 32'd0);

    for (int i = 0; i < 40; i++) begin
      t = pack(rand_fp16(), rand_fp16(), rand_fp16(), rand_fp16(), rand_fp16(), rand_fp16());
      model(t, xmn, xmx, ymn, ymx);
      run_job("random", t, 1'b0, '0, 0, xmn, xmx, ymn, ymx);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
